sec32_check_encoder: RTL and testbench

Pipelined single-error-correcting check-bit generator for 32-bit data words. It is the transmit-side counterpart of the C499 SEC corrector. For every accepted data word it computes the 8 check bits that give an all-zero syndrome in the corrector when its enable `r` is 1. It sits upstream of the corrector in the IP-dataset ECC path and adds valid/ready flow control, a one-shot error-injection port for corrector verification, and an encoded-word counter.

---
 rtl/sec32_check_encoder.sv | 138 +++++++++++++
 tb/tb_sec32_check_encoder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec32_check_encoder.sv
// sec32_check_encoder: two-stage SEC check-bit generator for 32-bit words.
// Ports: clk/rst; in_valid/in_ready/in_data; out_valid/out_ready/out_data/
//   out_check/out_injected; inj_req/inj_pos/inj_pending; word_count.
module sec32_check_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_check,
  output logic             out_injected,
  input  logic             inj_req,
  input  logic [5:0]       inj_pos,
  output logic             inj_pending,
  output logic [CNT_W-1:0] word_count
);

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [7:0]  f;
    logic [7:0]  xe;
    logic        inj;
    logic [5:0]  pos;
  } s1_t;

  s1_t         s1;
  logic [5:0]  pend_pos;
  logic        en;
  logic        in_hs;
  logic        out_hs;
  logic [7:0]  f_n;
  logic [7:0]  xe_n;
  logic [7:0]  g;
  logic [7:0]  chk;
  logic [31:0] dflip;
  logic [7:0]  cflip;
  logic        eff_inj;
  logic [5:0]  eff_pos;

  // One global enable: the whole pipe advances or the whole pipe holds.
  assign en     = !out_valid || out_ready;
  assign in_ready = en;
  assign in_hs  = in_valid && en;
  assign out_hs = out_valid && out_ready;

  // A request in the handshake cycle attaches to that very word.
  assign eff_inj = inj_pending || inj_req;
  assign eff_pos = inj_req ? inj_pos : pend_pos;

  always_comb begin
    f_n  = '0;
    xe_n = '0;
    for (int j = 0; j < 8; j++) begin
      f_n[j] = ^in_data[4*j +: 4];
    end
    for (int k = 0; k < 4; k++) begin
      xe_n[k] = in_data[k] ^ in_data[k+4]
              ^ in_data[k+8] ^ in_data[k+12];
    end
    for (int k = 4; k < 8; k++) begin
      xe_n[k] = in_data[k+12] ^ in_data[k+16]
              ^ in_data[k+20] ^ in_data[k+24];
    end
  end

  always_comb begin
    g[0] = s1.f[0] ^ s1.f[1];
    g[1] = s1.f[2] ^ s1.f[3];
    g[2] = s1.f[0] ^ s1.f[2];
    g[3] = s1.f[1] ^ s1.f[3];
    g[4] = s1.f[4] ^ s1.f[5];
    g[5] = s1.f[6] ^ s1.f[7];
    g[6] = s1.f[4] ^ s1.f[6];
    g[7] = s1.f[5] ^ s1.f[7];
    chk[3:0] = s1.xe[3:0] ^ g[7:4];
    chk[7:4] = s1.xe[7:4] ^ g[3:0];
  end

  // Positions 0..31 hit data, 32..39 (6'b100xxx) hit check bits.
  always_comb begin
    dflip = '0;
    cflip = '0;
    if (s1.inj && !s1.pos[5]) begin
      dflip = 32'd1 << s1.pos[4:0];
    end
    if (s1.inj && (s1.pos[5:3] == 3'b100)) begin
      cflip = 8'd1 << s1.pos[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= '0;
      pend_pos     <= '0;
      inj_pending  <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_check    <= '0;
      out_injected <= 1'b0;
      word_count   <= '0;
    end else begin
      if (in_hs) begin
        inj_pending <= 1'b0;
      end else if (inj_req) begin
        inj_pending <= 1'b1;
      end
      if (inj_req) begin
        pend_pos <= inj_pos;
      end
      if (en) begin
        s1.valid <= in_valid;
        if (in_hs) begin
          s1.data <= in_data;
          s1.f    <= f_n;
          s1.xe   <= xe_n;
          s1.inj  <= eff_inj;
          s1.pos  <= eff_pos;
        end
        out_valid <= s1.valid;
        if (s1.valid) begin
          out_data     <= s1.data ^ dflip;
          out_check    <= chk ^ cflip;
          out_injected <= s1.inj;
        end
      end
      if (out_hs) begin
        word_count <= word_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sec32_check_encoder.sv
// tb_sec32_check_encoder: scoreboard bench for sec32_check_encoder.
// Reference model uses parity masks derived from the check-bit rules.
module tb_sec32_check_encoder;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [7:0]       out_check;
  logic             out_injected;
  logic             inj_req;
  logic [5:0]       inj_pos;
  logic             inj_pending;
  logic [CNT_W-1:0] word_count;

  always #5 clk = ~clk;

  sec32_check_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_check(out_check),
    .out_injected(out_injected),
    .inj_req(inj_req), .inj_pos(inj_pos),
    .inj_pending(inj_pending), .word_count(word_count)
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  c;
    logic        inj;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int acc = 0;
  logic m_pend = 1'b0;
  logic [5:0] m_pos = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [31:0] mask[8];
  logic [7:0] ec[4];
  logic [31:0] w[3];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Each check bit is the parity of a fixed subset of data bits.
  task automatic build_masks();
    int na[8] = '{4, 6, 4, 5, 0, 2, 0, 1};
    int nb[8] = '{5, 7, 6, 7, 1, 3, 2, 3};
    for (int k = 0; k < 8; k++) begin
      int base;
      mask[k] = '0;
      base = (k < 4) ? k : k + 12;
      for (int m = 0; m < 4; m++) mask[k] ^= 32'd1 << (base + 4*m);
      for (int b = 0; b < 4; b++) begin
        mask[k] ^= 32'd1 << (4*na[k] + b);
        mask[k] ^= 32'd1 << (4*nb[k] + b);
      end
    end
  endtask

  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = ^(d & mask[k]);
    return r;
  endfunction

  always @(negedge clk) begin : model
    exp_t e;
    logic inj;
    logic [5:0] p;
    if (rst) begin
      q.delete();
      m_pend = 1'b0;
      m_cnt = '0;
    end else begin
      chk("inj_pending", inj_pending, m_pend);
      chk("word_count", word_count, m_cnt);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          chk("out_data", out_data, q[0].d);
          chk("out_check", out_check, q[0].c);
          chk("out_injected", out_injected, q[0].inj);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (out_valid && out_ready) m_cnt = m_cnt + 1'b1;
      if (in_valid && in_ready) begin
        inj = m_pend || inj_req;
        p = inj_req ? inj_pos : m_pos;
        e.d = in_data;
        e.c = ref_check(in_data);
        e.inj = inj;
        if (inj && p < 32) e.d[p] = ~e.d[p];
        if (inj && p >= 32 && p < 40) e.c[p-32] = ~e.c[p-32];
        q.push_back(e);
        acc++;
        m_pend = 1'b0;
      end else if (inj_req) begin
        m_pend = 1'b1;
        m_pos = inj_pos;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
    tick();
  endtask

  task automatic arm(input logic [5:0] p);
    inj_req = 1'b1;
    inj_pos = p;
    tick();
    inj_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_out(input logic [31:0] d, input logic [7:0] c,
                            input logic inj);
    int n = 0;
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("exp_valid", out_valid, 1);
    chk("exp_data", out_data, d);
    chk("exp_check", out_check, c);
    chk("exp_inj", out_injected, inj);
    tick();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    int target;
    int widx;
    build_masks();
    ec[0] = 8'h00; ec[1] = 8'h51; ec[2] = 8'h15; ec[3] = 8'h00;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    inj_req = 1'b0; inj_pos = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_check", out_check, 0);
    chk("rst_out_inj", out_injected, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_pend", inj_pending, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    fork
      begin
        send(32'h0000_0000);
        send(32'h0000_0001);
        send(32'h0001_0000);
        send(32'hFFFF_FFFF);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          chk("dir_valid", out_valid, 1);
          chk("dir_check", out_check, ec[i]);
          if (i < 3) @(negedge clk);
        end
      end
    join
    drain();
    chk("dir_wc4", word_count, 4);

    arm(6'd5);
    @(negedge clk);
    chk("pend_set", inj_pending, 1);
    tick();
    send(32'h0);
    @(negedge clk);
    chk("pend_clr", inj_pending, 0);
    expect_out(32'h20, 8'h00, 1'b1);
    arm(6'd35);
    send(32'h0);
    expect_out(32'h0, 8'h08, 1'b1);
    arm(6'd40);
    send(32'h0);
    expect_out(32'h0, 8'h00, 1'b1);
    inj_req = 1'b1;
    inj_pos = 6'd2;
    send(32'h0);
    inj_req = 1'b0;
    expect_out(32'h4, 8'h00, 1'b1);
    arm(6'd3);
    arm(6'd33);
    send(32'h0);
    expect_out(32'h0, 8'h02, 1'b1);
    send(32'h1);
    expect_out(32'h1, 8'h51, 1'b0);
    drain();

    for (int i = 0; i < 3; i++) w[i] = $urandom;
    out_ready = 1'b0;
    in_valid = 1'b1;
    widx = 0;
    in_data = w[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) widx++;
      tick();
      if (widx < 3) in_data = w[widx];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_accepted", widx, 2);
    chk("bp_hold", out_data, w[0]);
    tick();
    out_ready = 1'b1;
    n = 0;
    while (widx < 3 && n < 20) begin
      @(negedge clk);
      if (in_valid && in_ready) widx++;
      tick();
      n++;
      if (widx >= 3) in_valid = 1'b0;
    end
    chk("bp_all_in", widx, 3);
    drain();

    out_ready = 1'b0;
    send($urandom);
    send($urandom);
    arm(6'd9);
    do_reset();
    @(negedge clk);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_wc", word_count, 0);
    chk("rst2_pend", inj_pending, 0);
    chk("rst2_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();

    target = acc + 1000;
    n = 0;
    while (acc < target && n < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      inj_req = ($urandom_range(0, 15) == 0);
      inj_pos = 6'($urandom_range(0, 63));
      tick();
      n++;
    end
    chk("rand_done", acc >= target, 1);
    inj_req = 1'b0;
    drain();

    do_reset();
    target = acc + 65535;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (acc < target && n < 70000) begin
      in_data = $urandom;
      tick();
      n++;
    end
    drain();
    chk("wc_ffff", word_count, 16'hFFFF);
    send($urandom);
    drain();
    chk("wc_wrap", word_count, 0);

    chk("q_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
